// File: rtl/jk_bank_driver.sv
// Command sequencer for a bank of JK flip-flops: issues J/K excitation with a
// one-cycle shared enable, verifies the bank's q feedback and retries on mismatch.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             en_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_TOGGLE, OP_INC, OP_DEC} op_t;

  localparam logic [3:0]       MAX_RETRY_L = 4'(MAX_RETRY);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_t           state;
  logic [3:0]       retry_cnt;
  logic [WIDTH-1:0] expected;
  logic             wrap_r;

  logic [WIDTH-1:0] t_inc, t_dec;
  logic [WIDTH-1:0] nxt_j, nxt_k, nxt_exp;
  logic             nxt_wrap;
  logic             run_inc, run_dec;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Counter toggle masks: bit i flips when every lower bit is 1 (INC) or 0 (DEC).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    t_inc   = '0;
    t_dec   = '0;
    run_inc = 1'b1;
    run_dec = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_inc[i] = run_inc;
      t_dec[i] = run_dec;
      run_inc  = run_inc & q_fb[i];
      run_dec  = run_dec & ~q_fb[i];
    end
  end

  always_comb begin
    nxt_j    = '0;
    nxt_k    = '0;
    nxt_exp  = '0;
    nxt_wrap = 1'b0;
    case (op_t'(cmd_op))
      OP_LOAD: begin
        nxt_j   = cmd_data & ~q_fb;
        nxt_k   = ~cmd_data & q_fb;
        nxt_exp = cmd_data;
      end
      OP_TOGGLE: begin
        nxt_j   = cmd_data;
        nxt_k   = cmd_data;
        nxt_exp = q_fb ^ cmd_data;
      end
      OP_INC: begin
        nxt_j    = t_inc;
        nxt_k    = t_inc;
        nxt_exp  = q_fb + ONE;
        nxt_wrap = &q_fb;
      end
      OP_DEC: begin
        nxt_j    = t_dec;
        nxt_k    = t_dec;
        nxt_exp  = q_fb - ONE;
        nxt_wrap = ~|q_fb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      j_out     <= '0;
      k_out     <= '0;
      en_out    <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      retry_cnt <= '0;
      expected  <= '0;
      wrap_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            j_out     <= nxt_j;
            k_out     <= nxt_k;
            en_out    <= 1'b1;
            expected  <= nxt_exp;
            wrap_r    <= nxt_wrap;
            retry_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          en_out <= 1'b0;
          j_out  <= '0;
          k_out  <= '0;
          state  <= CHECK;
        end
        CHECK: begin
          if (q_fb == expected) begin
            done      <= 1'b1;
            wrap      <= wrap_r;
            retry_cnt <= '0;
            state     <= IDLE;
          end else if (retry_cnt < MAX_RETRY_L) begin
            // Retry drives the bank straight to the expected value from wherever it is now.
            retry_cnt <= retry_cnt + 4'd1;
            j_out     <= expected & ~q_fb;
            k_out     <= ~expected & q_fb;
            en_out    <= 1'b1;
            state     <= ISSUE;
          end else begin
            done      <= 1'b1;
            err       <= 1'b1;
            wrap      <= wrap_r;
            retry_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver driving a modelled bank of four JK cells.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] q_fb;
  logic [3:0] j_out, k_out;
  logic       en_out, busy, done, wrap, err;

  logic [3:0] bank_q;
  logic       stuck_en;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] LOAD = 2'b00, TOGGLE = 2'b01, INC = 2'b10, DEC = 2'b11;

  always #5 clk = ~clk;

  // JK bank: q+ = J&~q | ~K&q per cell, shared enable, same reset as the driver.
  always @(posedge clk) begin
    if (reset)       bank_q <= 4'h0;
    else if (en_out) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end

  assign q_fb = stuck_en ? 4'h3 : bank_q;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .q_fb(q_fb), .j_out(j_out),
    .k_out(k_out), .en_out(en_out), .busy(busy), .done(done), .wrap(wrap), .err(err)
  );

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] data,
                         input logic [3:0] ej, input logic [3:0] ek, input logic [3:0] eq,
                         input logic ewrap, input logic eerr, input int ecyc, input int eens);
    int   n;
    int   ens;
    logic stray;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    n = 1; ens = 0; stray = 1'b0;
    checks++;
    if (en_out !== 1'b1 || j_out !== ej || k_out !== ek || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s issue: en=%b j=%b k=%b busy=%b ready=%b, want en=1 j=%b k=%b busy=1 ready=0",
               name, en_out, j_out, k_out, busy, cmd_ready, ej, ek);
    end
    while (done !== 1'b1 && n < 20) begin
      if (en_out === 1'b1) ens++;
      if (wrap !== 1'b0 || err !== 1'b0) stray = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != ecyc) begin
      errors++;
      $display("FAIL %s latency: done after %0d cycles, want %0d", name, n, ecyc);
    end
    checks++;
    if (done !== 1'b1 || wrap !== ewrap || err !== eerr || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s flags: done=%b wrap=%b err=%b ready=%b, want done=1 wrap=%b err=%b ready=1",
               name, done, wrap, err, cmd_ready, ewrap, eerr);
    end
    checks++;
    if (q_fb !== eq) begin
      errors++;
      $display("FAIL %s bank: q=%h, want %h", name, q_fb, eq);
    end
    checks++;
    if (ens != eens || stray) begin
      errors++;
      $display("FAIL %s enable: en pulses=%0d stray_flags=%b, want %0d pulses and no stray flags",
               name, ens, stray, eens);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: done=%b wrap=%b err=%b one cycle later, want 0 0 0", name, done, wrap, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || en_out !== 1'b0 || j_out !== 4'h0 || k_out !== 4'h0 ||
        done !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b en=%b j=%b k=%b done=%b wrap=%b err=%b, want 1 0 0 0000 0000 0 0 0",
               cmd_ready, busy, en_out, j_out, k_out, done, wrap, err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    run_cmd("load_A",  LOAD, 4'hA, 4'b1010, 4'b0000, 4'hA, 1'b0, 1'b0, 3, 1);
    run_cmd("load_F",  LOAD, 4'hF, 4'b0101, 4'b0000, 4'hF, 1'b0, 1'b0, 3, 1);
  endtask

  task automatic test_inc_dec();
    run_cmd("inc_wrap", INC, 4'h0, 4'b1111, 4'b1111, 4'h0, 1'b1, 1'b0, 3, 1);
    run_cmd("dec_wrap", DEC, 4'h9, 4'b1111, 4'b1111, 4'hF, 1'b1, 1'b0, 3, 1);
    run_cmd("dec_F",    DEC, 4'h0, 4'b0001, 4'b0001, 4'hE, 1'b0, 1'b0, 3, 1);
    run_cmd("inc_E",    INC, 4'h0, 4'b0001, 4'b0001, 4'hF, 1'b0, 1'b0, 3, 1);
  endtask

  task automatic test_toggle();
    run_cmd("load_A2",   LOAD,   4'hA, 4'b0000, 4'b0101, 4'hA, 1'b0, 1'b0, 3, 1);
    run_cmd("toggle_5",  TOGGLE, 4'h5, 4'b0101, 4'b0101, 4'hF, 1'b0, 1'b0, 3, 1);
    run_cmd("toggle_0",  TOGGLE, 4'h0, 4'b0000, 4'b0000, 4'hF, 1'b0, 1'b0, 3, 1);
  endtask

  task automatic test_retry();
    stuck_en = 1'b1;
    run_cmd("stuck_load_C", LOAD, 4'hC, 4'b1100, 4'b0011, 4'h3, 1'b0, 1'b1, 5, 2);
    stuck_en = 1'b0;
  endtask

  task automatic test_reset_abort();
    int dones;
    cmd_valid = 1'b1;
    cmd_op    = LOAD;
    cmd_data  = 4'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (en_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue: en=%b, want 1", en_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (en_out !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || j_out !== 4'h0 || k_out !== 4'h0) begin
      errors++;
      $display("FAIL abort_state: en=%b ready=%b busy=%b done=%b j=%b k=%b, want 0 1 0 0 0000 0000",
               en_out, cmd_ready, busy, done, j_out, k_out);
    end
    reset = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || en_out === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || q_fb !== 4'h0) begin
      errors++;
      $display("FAIL abort_quiet: done/en seen %0d times, q=%h, want 0 times and q=0", dones, q_fb);
    end
  endtask

  task automatic test_back_to_back();
    int ens;
    int dones;
    ens = 0; dones = 0;
    cmd_valid = 1'b1;
    cmd_op    = TOGGLE;
    cmd_data  = 4'h1;
    repeat (3) begin
      @(negedge clk);
      if (en_out === 1'b1) ens++;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || q_fb !== 4'h1 || ens != 1 || dones != 1) begin
      errors++;
      $display("FAIL held_valid: done=%b ready=%b q=%h en_pulses=%0d dones=%0d, want 1 1 1 1 1",
               done, cmd_ready, q_fb, ens, dones);
    end
    cmd_data = 4'h2;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (en_out !== 1'b1 || j_out !== 4'b0010 || k_out !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_accept: en=%b j=%b k=%b, want 1 0010 0010", en_out, j_out, k_out);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || q_fb !== 4'h3) begin
      errors++;
      $display("FAIL b2b_done: done=%b err=%b q=%h, want 1 0 3", done, err, q_fb);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    stuck_en  = 1'b0;
    test_reset();
    test_load();
    test_inc_dec();
    test_toggle();
    test_retry();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
